// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit.
// Signed and unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// The operation runs on operand magnitudes, and the sign is fixed up afterwards.
// Latency is fixed at WIDTH+2 cycles from acceptance to the done pulse.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           stateReg, stateNext;
  logic [CW-1:0]    cntReg;
  logic             isDivReg;    // operation in flight is a divide
  logic             negQuoReg;   // product / quotient must be negated
  logic             negRemReg;   // remainder must be negated (negative dividend)
  logic             zeroDivReg;  // divide with a zero divisor
  logic [WIDTH-1:0] magReg;      // |a| for multiply, |b| for divide
  logic [WIDTH-1:0] accHiReg;    // partial product high half / partial remainder
  logic [WIDTH-1:0] accLoReg;    // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] hiReg, loReg;
  logic             dbzReg;

  logic             accept;
  logic             isSigned, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divDiff;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic [2*WIDTH-1:0] prodRaw, prodFix;
  logic [WIDTH-1:0] quoFix, remFix, fixHi, fixLo;

  // Operand conditioning: signedness from op[0], magnitudes for the iteration.
  always_comb begin
    isSigned = ~op[0];
    aNeg     = isSigned & a[WIDTH-1];
    bNeg     = isSigned & b[WIDTH-1];
    aMag     = aNeg ? -a : a;
    bMag     = bNeg ? -b : b;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mulSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, magReg} : '0);
    divShift = {accHiReg, accLoReg[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, magReg};
    stepHi   = mulSum[WIDTH:1];
    stepLo   = {mulSum[0], accLoReg[WIDTH-1:1]};
    if (isDivReg) begin
      // Non-negative difference means the divisor fits; the top two bits are then both zero.
      if (divDiff[WIDTH+1:WIDTH] == 2'b00) begin
        stepHi = divDiff[WIDTH-1:0];
        stepLo = {accLoReg[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = divShift[WIDTH-1:0];
        stepLo = {accLoReg[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction applied in FIX. A zero divisor leaves |a| in the remainder,
  // so the remainder fix restores a; the quotient is then forced to all ones.
  always_comb begin
    prodRaw = {accHiReg, accLoReg};
    prodFix = negQuoReg ? -prodRaw : prodRaw;
    quoFix  = negQuoReg ? -accLoReg : accLoReg;
    remFix  = negRemReg ? -accHiReg : accHiReg;
    fixHi   = prodFix[2*WIDTH-1:WIDTH];
    fixLo   = prodFix[WIDTH-1:0];
    if (isDivReg) begin
      fixHi = remFix;
      fixLo = zeroDivReg ? '1 : quoFix;
    end
  end

  // Next-state logic; cancel overrides everything, including a simultaneous start.
  always_comb begin
    stateNext = stateReg;
    accept    = 1'b0;
    busy      = (stateReg == CALC) || (stateReg == FIX);
    done      = (stateReg == DONE);
    if (cancel) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE, DONE: begin
          if (start) begin
            accept    = 1'b1;
            stateNext = CALC;
          end else begin
            stateNext = IDLE;
          end
        end
        CALC:    if (cntReg == LAST_STEP) stateNext = FIX;
        FIX:     stateNext = DONE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Operand capture on acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntReg     <= '0;
      isDivReg   <= 1'b0;
      negQuoReg  <= 1'b0;
      negRemReg  <= 1'b0;
      zeroDivReg <= 1'b0;
      magReg     <= '0;
      accHiReg   <= '0;
      accLoReg   <= '0;
    end else if (accept) begin
      cntReg     <= '0;
      isDivReg   <= op[1];
      negQuoReg  <= aNeg ^ bNeg;
      negRemReg  <= aNeg;
      zeroDivReg <= op[1] & (b == '0);
      magReg     <= op[1] ? bMag : aMag;
      accHiReg   <= '0;
      accLoReg   <= op[1] ? aMag : bMag;
    end else if (stateReg == CALC && !cancel) begin
      accHiReg <= stepHi;
      accLoReg <= stepLo;
      cntReg   <= cntReg + CW'(1);
    end
  end

  // Result registers, written only by an uncancelled FIX cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiReg  <= '0;
      loReg  <= '0;
      dbzReg <= 1'b0;
    end else if (stateReg == FIX && !cancel) begin
      hiReg  <= fixHi;
      loReg  <= fixLo;
      dbzReg <= isDivReg & zeroDivReg;
    end
  end

  assign hi          = hiReg;
  assign lo          = loReg;
  assign div_by_zero = dbzReg;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected results, monitor checks on done.
module tb_mdu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           stamp;
    int           tag;
  } exp_t;

  exp_t         sb[$];
  exp_t         monE;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           doneSeen;
  logic [W-1:0] lastHi = '0, lastLo = '0;
  logic         lastDbz = 1'b0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, required no pending op (cycle %0d)", cyc);
      end else begin
        monE = sb.pop_front();
        chk("hi", {32'h0, hi}, {32'h0, monE.hi});
        chk("lo", {32'h0, lo}, {32'h0, monE.lo});
        chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, monE.dbz});
        chk("latency", 64'(cyc + 1 - monE.stamp), 64'(W + 2));
        $display("txn %0d: hi=0x%08h lo=0x%08h dbz=%0b latency=%0d", monE.tag, hi, lo,
                 div_by_zero, cyc + 1 - monE.stamp);
      end
    end
  end

  // Drive one request at the current negedge; accepted at the following posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic track, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ed, input int tag);
    exp_t e;
    op = o; a = av; b = bv; start = 1'b1;
    if (track) begin
      e.hi = eh; e.lo = el; e.dbz = ed; e.stamp = cyc + 1; e.tag = tag;
      sb.push_back(e);
      lastHi = eh; lastLo = el; lastDbz = ed;
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'h0, busy}, 64'd0);
    chk("reset_done", {63'h0, done}, 64'd0);
    chk("reset_hi", {32'h0, hi}, 64'd0);
    chk("reset_lo", {32'h0, lo}, 64'd0);
    chk("reset_dbz", {63'h0, div_by_zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULT -3 * 5 with busy timing and a start ignored while busy
    issue(2'b00, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 1);
    chk("busy_after_accept", {63'h0, busy}, 64'd1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    chk("busy_in_fix", {63'h0, busy}, 64'd1);
    chk("no_done_in_fix", {63'h0, done}, 64'd0);
    @(negedge clk);
    chk("busy_low_in_done", {63'h0, busy}, 64'd0);
    chk("done_pulse", {63'h0, done}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'h0, done}, 64'd0);
    chk("ignored_start_no_op", {63'h0, busy}, 64'd0);

    // MULTU max*max, then DIV -7/2 started in the DONE cycle
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, 2);
    repeat (33) @(negedge clk);
    chk("b2b_in_done", {63'h0, done}, 64'd1);
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 3);
    waitDone("div_m7_2");

    issue(2'b11, 32'd10, 32'd0, 1, 32'h0000000A, 32'hFFFFFFFF, 1, 4);
    waitDone("divu_by_zero");
    issue(2'b01, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0, 5);
    waitDone("multu_3_4");
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'h80000000, 0, 6);
    waitDone("div_overflow");
    issue(2'b10, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 0, 7);
    waitDone("div_7_m2");
    issue(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 1, 32'hFFFFFFFF, 32'd3, 0, 8);
    waitDone("div_m7_m2");
    issue(2'b10, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 9);
    waitDone("div_m5_by_zero");
    issue(2'b00, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'd0, 0, 10);
    waitDone("mult_minmin");
    issue(2'b01, 32'h12345678, 32'h10, 1, 32'd1, 32'h23456780, 0, 11);
    waitDone("multu_shift");

    // Cancel mid-MULTU; a start while busy is ignored
    issue(2'b01, 32'd5, 32'd6, 0, '0, '0, 0, 12);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("busy_after_cancel", {63'h0, busy}, 64'd0);
    doneSeen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    chk("no_done_after_cancel", 64'(doneSeen), 64'd0);
    chk("hi_kept_after_cancel", {32'h0, hi}, {32'h0, lastHi});
    chk("lo_kept_after_cancel", {32'h0, lo}, {32'h0, lastLo});
    chk("dbz_kept_after_cancel", {63'h0, div_by_zero}, {63'h0, lastDbz});

    // Cancel wins over a simultaneous start
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_beats_start", {63'h0, busy}, 64'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    chk("no_done_cancel_start", 64'(doneSeen), 64'd0);

    // Asynchronous reset mid-DIV, then a fresh DIVU
    issue(2'b10, 32'd100, 32'd7, 0, '0, '0, 0, 13);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {63'h0, busy}, 64'd0);
    chk("async_rst_done", {63'h0, done}, 64'd0);
    chk("async_rst_hi", {32'h0, hi}, 64'd0);
    chk("async_rst_lo", {32'h0, lo}, 64'd0);
    chk("async_rst_dbz", {63'h0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 14);
    waitDone("divu_100_7");
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
